// File: rtl/regfile_wb.sv
// regfile_wb: MEM/WB pipeline latch feeding a 32-entry register array,
// with two combinational read ports that bypass the pending writeback entry.
module regfile_wb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [4:0]        writeReg,
  input  logic [DATA_W-1:0] writeData,
  input  logic              stall,
  input  logic              flush,
  input  logic [4:0]        readReg1,
  input  logic [4:0]        readReg2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic              wbValid,
  output logic [4:0]        wbReg
);

  localparam int unsigned ADDR_W = 5;

  logic              latchValid;
  logic [ADDR_W-1:0] latchReg;
  logic [DATA_W-1:0] latchData;
  logic [DATA_W-1:0] regs [NREGS];

  // WB latch: reset > flush > stall > load; writes to r0 never become valid
  always_ff @(posedge clk) begin
    if (reset) begin
      latchValid <= 1'b0;
      latchReg   <= '0;
      latchData  <= '0;
    end else if (flush) begin
      latchValid <= 1'b0;
      latchReg   <= '0;
      latchData  <= '0;
    end else if (!stall) begin
      latchValid <= RegWrite && (writeReg != ADDR_W'(0));
      latchReg   <= writeReg;
      latchData  <= writeData;
    end
  end

  // Array commit from the latch; a reset discards the pending entry
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs[i] <= '0;
      end
    end else if (latchValid && (latchReg != ADDR_W'(0))) begin
      regs[latchReg] <= latchData;
    end
  end

  // Read port 1: r0 forced to zero, then bypass from latch, then array
  always_comb begin
    readData1 = '0;
    if (readReg1 == ADDR_W'(0)) begin
      readData1 = '0;
    end else if (latchValid && (latchReg == readReg1)) begin
      readData1 = latchData;
    end else begin
      readData1 = regs[readReg1];
    end
  end

  // Read port 2: same priority as port 1
  always_comb begin
    readData2 = '0;
    if (readReg2 == ADDR_W'(0)) begin
      readData2 = '0;
    end else if (latchValid && (latchReg == readReg2)) begin
      readData2 = latchData;
    end else begin
      readData2 = regs[readReg2];
    end
  end

  assign wbValid = latchValid;
  assign wbReg   = latchReg;

endmodule

// File: tb/tb_regfile_wb.sv
// tb_regfile_wb: directed bench for the writeback register file.
module tb_regfile_wb;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        stall;
  logic        flush;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic        wbValid;
  logic [4:0]  wbReg;

  int passCnt = 0;
  int totalCnt = 0;

  regfile_wb #(.DATA_W(32), .NREGS(32)) dut (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .writeReg(writeReg),
    .writeData(writeData), .stall(stall), .flush(flush),
    .readReg1(readReg1), .readReg2(readReg2),
    .readData1(readData1), .readData2(readData2),
    .wbValid(wbValid), .wbReg(wbReg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) begin
      passCnt++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; RegWrite = 1'b0; writeReg = '0; writeData = '0;
    stall = 1'b0; flush = 1'b0; readReg1 = '0; readReg2 = '0;
    tick();
    reset = 1'b0;
    #1;
    check("rst_wbValid", 32'(wbValid), 32'h0);
    check("rst_wbReg", 32'(wbReg), 32'h0);
    check("rst_rd1_r0", readData1, 32'h0);
    readReg1 = 5'd1; readReg2 = 5'd31; #1;
    check("rst_rd1_r1", readData1, 32'h0);
    check("rst_rd2_r31", readData2, 32'h0);

    // Write then read: bypass then array
    RegWrite = 1'b1; writeReg = 5'd31; writeData = 32'hDEADBEEF;
    tick();
    RegWrite = 1'b0; readReg1 = 5'd31; #1;
    check("wr_bypass", readData1, 32'hDEADBEEF);
    check("wr_wbValid", 32'(wbValid), 32'h1);
    check("wr_wbReg", 32'(wbReg), 32'd31);
    tick();
    check("wr_array", readData1, 32'hDEADBEEF);
    check("wr_wbValid_off", 32'(wbValid), 32'h0);

    // R0 protection
    RegWrite = 1'b1; writeReg = 5'd0; writeData = 32'h12345678;
    tick();
    RegWrite = 1'b0; readReg1 = 5'd0; #1;
    check("r0_wbValid", 32'(wbValid), 32'h0);
    check("r0_rd1_a", readData1, 32'h0);
    tick();
    check("r0_rd1_b", readData1, 32'h0);

    // Back-to-back writes to reg 24
    RegWrite = 1'b1; writeReg = 5'd24; writeData = 32'h1;
    tick();
    readReg2 = 5'd24; writeData = 32'h2; #1;
    check("b2b_first", readData2, 32'h1);
    tick();
    RegWrite = 1'b0; #1;
    check("b2b_second_bypass", readData2, 32'h2);
    tick();
    check("b2b_second_array", readData2, 32'h2);
    readReg1 = 5'd24; #1;
    check("b2b_same_addr_p1", readData1, 32'h2);

    // Flush squashes the write to reg 7
    RegWrite = 1'b1; writeReg = 5'd7; writeData = 32'hA5; flush = 1'b1;
    tick();
    flush = 1'b0; RegWrite = 1'b0; readReg1 = 5'd7; #1;
    check("flush_wbValid", 32'(wbValid), 32'h0);
    check("flush_rd1", readData1, 32'h0);
    tick();
    check("flush_rd1_later", readData1, 32'h0);

    // Write 5A then stall 3 cycles while presenting FF
    RegWrite = 1'b1; writeReg = 5'd7; writeData = 32'h5A;
    tick();
    writeData = 32'hFF; stall = 1'b1; #1;
    check("stall_wbReg_0", 32'(wbReg), 32'd7);
    check("stall_rd1_0", readData1, 32'h5A);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_wbReg", 32'(wbReg), 32'd7);
      check("stall_rd1", readData1, 32'h5A);
    end
    stall = 1'b0; RegWrite = 1'b0;
    tick();
    check("post_stall_rd1", readData1, 32'h5A);
    check("post_stall_wbValid", 32'(wbValid), 32'h0);

    // Flush and stall together: flush wins, pending entry still commits
    RegWrite = 1'b1; writeReg = 5'd9; writeData = 32'h99;
    tick();
    RegWrite = 1'b0; flush = 1'b1; stall = 1'b1;
    tick();
    flush = 1'b0; stall = 1'b0; readReg2 = 5'd9; #1;
    check("fs_wbValid", 32'(wbValid), 32'h0);
    check("fs_wbReg", 32'(wbReg), 32'h0);
    check("fs_commit", readData2, 32'h99);

    // Reset mid-operation discards the latched write
    RegWrite = 1'b1; writeReg = 5'd3; writeData = 32'hCAFE;
    tick();
    RegWrite = 1'b0; readReg1 = 5'd3; #1;
    check("mid_bypass", readData1, 32'hCAFE);
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    check("mid_rd1_r3", readData1, 32'h0);
    check("mid_wbValid", 32'(wbValid), 32'h0);
    readReg2 = 5'd31; #1;
    check("mid_rd2_r31", readData2, 32'h0);
    tick();
    check("mid_rd1_r3_later", readData1, 32'h0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
